// File: rtl/mult_switch_seq.sv
// Job sequencer for a row of multiplier switches: loads one stationary operand per
// switch, broadcasts the streaming vectors, then waits for every product to come back.
module mult_switch_seq #(
    parameter int NUM_MS       = 8,
    parameter int IN_DATA_TYPE = 16,
    parameter int CNT_W        = 8
) (
    input  logic                           CLK,
    input  logic                           rst,
    input  logic                           i_start,
    input  logic [CNT_W-1:0]               i_num_stream,
    input  logic                           i_ld_valid,
    input  logic [IN_DATA_TYPE-1:0]        i_ld_data,
    output logic                           o_ld_ready,
    input  logic                           i_st_valid,
    input  logic [NUM_MS*IN_DATA_TYPE-1:0] i_st_data,
    output logic                           o_st_ready,
    output logic [NUM_MS-1:0]              o_ms_valid,
    output logic [NUM_MS-1:0]              o_ms_stationary,
    output logic [NUM_MS*IN_DATA_TYPE-1:0] o_ms_data,
    input  logic [NUM_MS-1:0]              i_ms_ovalid,
    output logic                           o_busy,
    output logic                           o_done,
    output logic                           o_err
);

    localparam int IDX_W = $clog2(NUM_MS);
    localparam int DW    = NUM_MS * IN_DATA_TYPE;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_MS - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [NUM_MS-1:0] LANE0    = {{(NUM_MS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   num_q, num_d;
    logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]   ret_cnt_q, ret_cnt_d;
    logic [IDX_W-1:0]   ld_idx_q, ld_idx_d;
    logic               err_q, err_d;
    logic [NUM_MS-1:0]  ms_valid_q, ms_valid_d;
    logic [NUM_MS-1:0]  ms_stat_q, ms_stat_d;
    logic [DW-1:0]      ms_data_q, ms_data_d;

    logic               ld_acc;
    logic               st_acc;
    logic               ret_inc;
    logic               err_clr;
    logic [CNT_W-1:0]   ret_next;

    // A healthy row returns products on every lane together; anything else is a fault.
    function automatic logic lanes_disagree(input logic [NUM_MS-1:0] v);
        return (v != {NUM_MS{1'b0}}) && (v != {NUM_MS{1'b1}});
    endfunction

    assign o_ld_ready      = (state_q == S_LOAD);
    assign o_st_ready      = (state_q == S_STREAM);
    assign o_busy          = (state_q != S_IDLE);
    assign o_done          = (state_q == S_DONE);
    assign o_err           = err_q;
    assign o_ms_valid      = ms_valid_q;
    assign o_ms_stationary = ms_stat_q;
    assign o_ms_data       = ms_data_q;

    assign ld_acc   = o_ld_ready & i_ld_valid;
    assign st_acc   = o_st_ready & i_st_valid;
    // Products can already return while later vectors are still streaming.
    assign ret_inc  = ((state_q == S_STREAM) || (state_q == S_DRAIN)) & i_ms_ovalid[0];
    assign ret_next = ret_cnt_q + {{(CNT_W-1){1'b0}}, ret_inc};

    // Next-state, counters and the one-cycle switch-row drive.
    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        issue_cnt_d = issue_cnt_q;
        ret_cnt_d   = ret_cnt_q;
        ld_idx_d    = ld_idx_q;
        err_clr     = 1'b0;
        ms_valid_d  = {NUM_MS{1'b0}};
        ms_stat_d   = {NUM_MS{1'b0}};
        ms_data_d   = {DW{1'b0}};

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d     = S_LOAD;
                    num_d       = i_num_stream;
                    issue_cnt_d = CNT_ZERO;
                    ret_cnt_d   = CNT_ZERO;
                    ld_idx_d    = {IDX_W{1'b0}};
                    err_clr     = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (ld_acc) begin
                    ms_valid_d = LANE0 << ld_idx_q;
                    ms_stat_d  = LANE0 << ld_idx_q;
                    ms_data_d  = {NUM_MS{i_ld_data}};
                    if (ld_idx_q == LAST_IDX) begin
                        state_d = (num_q == CNT_ZERO) ? S_DONE : S_STREAM;
                    end else begin
                        ld_idx_d = ld_idx_q + IDX_ONE;
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_STREAM: begin
                ret_cnt_d = ret_next;
                if (st_acc) begin
                    ms_valid_d  = {NUM_MS{1'b1}};
                    ms_data_d   = i_st_data;
                    issue_cnt_d = issue_cnt_q + CNT_ONE;
                    if (issue_cnt_q == (num_q - CNT_ONE)) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_STREAM;
                    end
                end else begin
                    state_d = S_STREAM;
                end
            end
            S_DRAIN: begin
                ret_cnt_d = ret_next;
                // >= covers the case where every product arrived during streaming.
                if (ret_next >= num_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        err_d = (err_clr ? 1'b0 : err_q) | lanes_disagree(i_ms_ovalid);
    end

    // State, counters, sticky error and registered switch-row outputs.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            num_q       <= CNT_ZERO;
            issue_cnt_q <= CNT_ZERO;
            ret_cnt_q   <= CNT_ZERO;
            ld_idx_q    <= {IDX_W{1'b0}};
            err_q       <= 1'b0;
            ms_valid_q  <= {NUM_MS{1'b0}};
            ms_stat_q   <= {NUM_MS{1'b0}};
            ms_data_q   <= {DW{1'b0}};
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            ld_idx_q    <= ld_idx_d;
            err_q       <= err_d;
            ms_valid_q  <= ms_valid_d;
            ms_stat_q   <= ms_stat_d;
            ms_data_q   <= ms_data_d;
        end
    end

endmodule

// File: tb/tb_mult_switch_seq.sv
// Randomized bench for mult_switch_seq: a job-level reference model predicts every
// output each cycle, and a fixed-latency row model returns products.
module tb_mult_switch_seq;

    localparam int N  = 8;
    localparam int W  = 16;
    localparam int C  = 8;
    localparam int DW = N * W;

    localparam int P_IDLE   = 0;
    localparam int P_LOAD   = 1;
    localparam int P_STREAM = 2;
    localparam int P_DRAIN  = 3;
    localparam int P_DONE   = 4;

    logic          CLK = 1'b0;
    logic          rst;
    logic          i_start;
    logic [C-1:0]  i_num_stream;
    logic          i_ld_valid;
    logic [W-1:0]  i_ld_data;
    logic          o_ld_ready;
    logic          i_st_valid;
    logic [DW-1:0] i_st_data;
    logic          o_st_ready;
    logic [N-1:0]  o_ms_valid;
    logic [N-1:0]  o_ms_stationary;
    logic [DW-1:0] o_ms_data;
    logic [N-1:0]  i_ms_ovalid;
    logic          o_busy;
    logic          o_done;
    logic          o_err;

    mult_switch_seq #(.NUM_MS(N), .IN_DATA_TYPE(W), .CNT_W(C)) dut (
        .CLK(CLK), .rst(rst), .i_start(i_start), .i_num_stream(i_num_stream),
        .i_ld_valid(i_ld_valid), .i_ld_data(i_ld_data), .o_ld_ready(o_ld_ready),
        .i_st_valid(i_st_valid), .i_st_data(i_st_data), .o_st_ready(o_st_ready),
        .o_ms_valid(o_ms_valid), .o_ms_stationary(o_ms_stationary), .o_ms_data(o_ms_data),
        .i_ms_ovalid(i_ms_ovalid), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // job-level model state
    int            m_phase = P_IDLE;
    int            m_n, m_loads, m_issued, m_returned;
    bit            m_err = 1'b0;
    logic [N-1:0]  e_valid = '0;
    logic [N-1:0]  e_stat  = '0;
    logic [DW-1:0] e_data  = '0;

    int cyc = 0;
    int job_lat, st_cyc, ldp, stp;
    bit pat, directed, inject_en, injected;
    int ret_q[$];

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_ctrl"}, 160'({o_ld_ready, o_st_ready, o_busy, o_done, o_err}),
              160'({m_phase == P_LOAD, m_phase == P_STREAM, m_phase != P_IDLE,
                    m_phase == P_DONE, m_err}));
        check({tag, "_ms"}, 160'({o_ms_valid, o_ms_stationary, o_ms_data}),
              160'({e_valid, e_stat, e_data}));
    endtask

    task automatic model_reset();
        m_phase = P_IDLE;
        m_err   = 1'b0;
        e_valid = '0;
        e_stat  = '0;
        e_data  = '0;
    endtask

    // Advance the job model by one accepting edge using the inputs present at that edge.
    task automatic model_edge();
        logic [N-1:0] ov;
        ov      = i_ms_ovalid;
        e_valid = '0;
        e_stat  = '0;
        e_data  = '0;
        case (m_phase)
            P_IDLE: if (i_start) begin
                m_phase = P_LOAD; m_n = int'(i_num_stream);
                m_loads = 0; m_issued = 0; m_returned = 0; m_err = 1'b0;
            end
            P_LOAD: if (i_ld_valid) begin
                e_valid = N'(1) << m_loads;
                e_stat  = e_valid;
                e_data  = {N{i_ld_data}};
                m_loads++;
                if (m_loads == N) m_phase = (m_n == 0) ? P_DONE : P_STREAM;
            end
            P_STREAM: begin
                if (ov[0]) m_returned++;
                if (i_st_valid) begin
                    e_valid = '1;
                    e_data  = i_st_data;
                    m_issued++;
                    ret_q.push_back(cyc + job_lat);
                    if (m_issued == m_n) m_phase = P_DRAIN;
                end
            end
            P_DRAIN: begin
                if (ov[0]) m_returned++;
                if (m_returned >= m_n) m_phase = P_DONE;
            end
            default: m_phase = P_IDLE;
        endcase
        if (ov != '0 && ov != '1) m_err = 1'b1;
    endtask

    task automatic drive_inputs();
        i_start      = (m_phase != P_IDLE) && ($urandom_range(0, 3) == 0);
        i_num_stream = C'($urandom);
        i_ld_valid   = ($urandom_range(0, 99) < ldp);
        i_ld_data    = directed ? (16'h3F80 + 16'(m_loads)) : 16'($urandom);
        if (m_phase == P_STREAM) begin
            i_st_valid = pat ? (st_cyc % 2 == 0) : ($urandom_range(0, 99) < stp);
            st_cyc++;
        end else begin
            i_st_valid = 1'($urandom_range(0, 1));
        end
        i_st_data   = {$urandom, $urandom, $urandom, $urandom};
        i_ms_ovalid = '0;
        if (ret_q.size() > 0 && ret_q[0] == cyc) begin
            i_ms_ovalid = '1;
            void'(ret_q.pop_front());
        end
        if (inject_en && !injected && m_phase == P_DRAIN) begin
            i_ms_ovalid = 8'h7F;
            injected    = 1'b1;
        end
    endtask

    task automatic run_job(input int num, input int lat, input int lp, input int sp,
                           input bit pt, input bit dir, input bit inj, input bit abort);
        bit finished = 1'b0;
        ret_q.delete();
        job_lat = lat; ldp = lp; stp = sp; pat = pt; directed = dir;
        inject_en = inj; injected = 1'b0; st_cyc = 0;
        drive_inputs();
        i_start      = 1'b1;
        i_num_stream = C'(num);
        for (int k = 0; k < 400; k++) begin
            @(posedge CLK);
            cyc++;
            model_edge();
            #1;
            check_outputs("cycle");
            if (abort && m_phase == P_STREAM && st_cyc >= 2) begin
                #2 rst = 1'b1;
                #1;
                check("rst_async", 160'({o_ld_ready, o_st_ready, o_busy, o_done, o_err,
                                         o_ms_valid, o_ms_stationary, o_ms_data}), 160'(0));
                model_reset();
                i_start = 1'b0; i_ld_valid = 1'b0; i_st_valid = 1'b0; i_ms_ovalid = '0;
                @(posedge CLK);
                cyc++;
                #1;
                check_outputs("rst_hold");
                rst = 1'b0;
                finished = 1'b1;
                break;
            end
            if (m_phase == P_IDLE) begin
                finished = 1'b1;
                break;
            end
            drive_inputs();
        end
        if (!finished) check("timeout", 160'(0), 160'(1));
        i_start = 1'b0; i_ld_valid = 1'b0; i_st_valid = 1'b0; i_ms_ovalid = '0;
    endtask

    initial begin
        rst = 1'b1; i_start = 1'b0; i_num_stream = '0; i_ld_valid = 1'b0; i_ld_data = '0;
        i_st_valid = 1'b0; i_st_data = '0; i_ms_ovalid = '0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_outputs("reset");
        rst = 1'b0;
        @(posedge CLK);
        cyc++;
        model_edge();
        #1;
        check_outputs("idle");

        run_job(3, 2, 100, 0, 1'b1, 1'b1, 1'b0, 1'b0);  // load 0x3F80.., stream 1,0,1,0,1, drain
        run_job(0, 2, 100, 0, 1'b0, 1'b1, 1'b0, 1'b0);  // zero-length job
        run_job(4, 3, 70, 60, 1'b0, 1'b0, 1'b1, 1'b0);  // lane disagreement in DRAIN
        run_job(2, 1, 100, 100, 1'b0, 1'b0, 1'b0, 1'b0); // start clears sticky error
        run_job(5, 2, 100, 100, 1'b0, 1'b0, 1'b0, 1'b1); // async reset mid-stream
        for (int j = 0; j < 8; j++) begin
            run_job($urandom_range(1, 6), $urandom_range(1, 4), $urandom_range(50, 100),
                    $urandom_range(40, 100), 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        end
        @(posedge CLK);
        cyc++;
        model_edge();
        #1;
        check_outputs("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
